// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI configuration-register target.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pad synchronizer with one history flop for single-cycle rise/fall pulses.
// RST_VAL is the idle pad level so that reset release does not fake an edge.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= {(STAGES+1){RST_VAL}};
        else        r_sync <= {r_sync[STAGES-1:0], i_async};
    end

    // r_sync[STAGES] is the history flop, one cycle behind the synchronized level
    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_sync[STAGES];
    assign o_fall  = ~r_sync[STAGES-1] & r_sync[STAGES];

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target holding the five PWM configuration registers (16-bit write frames).
// Define SPI_READBACK_EN to return register[addr] on cipo during read frames.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    logic w_sclk_rise, w_sclk_fall, w_copi, w_ncs_fall, w_ncs_rise;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_level(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_async(copi),
        .o_level(w_copi), .o_rise(), .o_fall());

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_async(ncs),
        .o_level(), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));

    state_t      r_state, w_state_nxt;
    logic [15:0] r_shift;
    logic [4:0]  r_cnt;
    logic [7:0]  r_regs [5];
    logic        w_clr, w_shift_en, w_commit;
    logic [15:0] w_shift_nxt;

    assign w_shift_nxt = {r_shift[14:0], w_copi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ncs_fall) w_state_nxt = SHIFT;
            SHIFT:   if (w_ncs_rise) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_clr      = (r_state == IDLE) && w_ncs_fall;
        w_shift_en = (r_state == SHIFT) && w_sclk_rise;
        // only an exact 16-bit write frame to a known address lands
        w_commit   = (r_state == COMMIT) && (r_cnt == 5'(FRAME_BITS))
                     && r_shift[15] && (r_shift[14:8] <= MAX_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_shift_nxt;
            if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            case (r_shift[14:8])
                ADDR_EN_OUT_7_0:  r_regs[0] <= r_shift[7:0];
                ADDR_EN_OUT_15_8: r_regs[1] <= r_shift[7:0];
                ADDR_EN_PWM_7_0:  r_regs[2] <= r_shift[7:0];
                ADDR_EN_PWM_15_8: r_regs[3] <= r_shift[7:0];
                ADDR_PWM_DUTY:    r_regs[4] <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];

`ifdef SPI_READBACK_EN
    logic [7:0] r_tx;
    logic       r_cipo;
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        if (w_shift_nxt[6:0] <= MAX_A) begin
            case (w_shift_nxt[6:0])
                ADDR_EN_OUT_7_0:  w_rd_data = r_regs[0];
                ADDR_EN_OUT_15_8: w_rd_data = r_regs[1];
                ADDR_EN_PWM_7_0:  w_rd_data = r_regs[2];
                ADDR_EN_PWM_15_8: w_rd_data = r_regs[3];
                ADDR_PWM_DUTY:    w_rd_data = r_regs[4];
                default:          w_rd_data = 8'h00;
            endcase
        end
    end

    // r_tx stays zero outside a read frame, so falls before the latch shift out zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (r_state != SHIFT || w_ncs_rise) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_shift_en && r_cnt == 5'd7 && !w_shift_nxt[7]) begin
            r_tx <= w_rd_data;
        end else if (w_sclk_fall) begin
            r_cipo <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
        end
    end

    assign cipo = r_cipo;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed-vector bench for spi_reg_peripheral: SPI frames at f_clk/8, register and cipo checks.
module tb_spi_reg_peripheral;

    localparam int SYNC = 2;
`ifdef SPI_READBACK_EN
    localparam logic [15:0] RB_EXP = 16'h0033;
`else
    localparam logic [15:0] RB_EXP = 16'h0000;
`endif

    logic       clk = 1'b0;
    logic       rst_n, sclk, copi, ncs;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;
    logic [15:0] rx;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        chk({tag, "_r0"}, {24'h0, r0}, {24'h0, e0});
        chk({tag, "_r1"}, {24'h0, r1}, {24'h0, e1});
        chk({tag, "_r2"}, {24'h0, r2}, {24'h0, e2});
        chk({tag, "_r3"}, {24'h0, r3}, {24'h0, e3});
        chk({tag, "_r4"}, {24'h0, r4}, {24'h0, e4});
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ncs = 1'b0;
        rx  = '0;
        repeat (4) @(negedge clk);
    endtask

    // MSB first; cipo is sampled just before each sclk rise, as the controller would
    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            copi = d[n-1-i];
            repeat (4) @(negedge clk);
            rx   = {rx[14:0], cipo};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        ncs  = 1'b1;
        copi = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] d, input int n);
        frame_begin();
        send_bits(d, n);
        frame_end();
    endtask

    initial begin
        rst_n = 1'b0;
        sclk  = 1'($urandom_range(0, 1));
        copi  = 1'($urandom_range(0, 1));
        ncs   = 1'($urandom_range(0, 1));
        rx    = '0;
        wait_edges(3);
        chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst_cipo", {31'h0, cipo}, 32'h0);

        @(negedge clk);
        sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        rst_n = 1'b1;
        wait_edges(8);
        chk_regs("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // write 0x55 to reg 0, then latency: unchanged at edge SYNC+1, written at SYNC+2
        send_frame(32'h8055, 16);
        wait_edges(SYNC + 1);
        chk("lat_before", {24'h0, r0}, 32'h00);
        wait_edges(1);
        chk("lat_after", {24'h0, r0}, 32'h55);
        wait_edges(6);
        chk_regs("wr0", 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);

        send_frame(32'h84C0, 16);
        wait_edges(8);
        chk_regs("duty", 8'h55, 8'h00, 8'h00, 8'h00, 8'hC0);

        send_frame(32'h85FF, 16);
        wait_edges(8);
        chk_regs("bad_addr", 8'h55, 8'h00, 8'h00, 8'h00, 8'hC0);

        send_frame(32'h081A, 12);
        wait_edges(8);
        chk_regs("short", 8'h55, 8'h00, 8'h00, 8'h00, 8'hC0);

        send_frame(32'h82F0F, 20);
        wait_edges(8);
        chk_regs("long", 8'h55, 8'h00, 8'h00, 8'h00, 8'hC0);

        send_frame(32'h82F0, 16);
        wait_edges(8);
        chk_regs("after_long", 8'h55, 8'h00, 8'hF0, 8'h00, 8'hC0);

        // sclk toggling with ncs high must not leave stray bits behind
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(negedge clk);
            copi = 1'b1; sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        copi = 1'b0;
        send_frame(32'h8477, 16);
        wait_edges(8);
        chk_regs("ncs_hi_sclk", 8'h55, 8'h00, 8'hF0, 8'h00, 8'h77);

        // ncs released after 9 bits
        send_frame(32'h83AA >> 7, 9);
        wait_edges(8);
        chk_regs("abort9", 8'h55, 8'h00, 8'hF0, 8'h00, 8'h77);

        // reset pulse after 10 bits, then the rest of the frame
        frame_begin();
        send_bits(32'h83AA >> 6, 10);
        @(negedge clk);
        rst_n = 1'b0;
        wait_edges(1);
        chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(32'h83AA & 32'h3F, 6);
        frame_end();
        wait_edges(8);
        chk_regs("after_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        send_frame(32'h83AA, 16);
        wait_edges(8);
        chk_regs("wr3", 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00);

        send_frame(32'h8133, 16);
        wait_edges(8);
        chk_regs("wr1", 8'h00, 8'h33, 8'h00, 8'hAA, 8'h00);

        send_frame(32'h0100, 16);
        chk("rb_data", {16'h0, rx}, {16'h0, RB_EXP});
        wait_edges(8);
        chk("rb_cipo_idle", {31'h0, cipo}, 32'h0);
        chk_regs("rd", 8'h00, 8'h33, 8'h00, 8'hAA, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI target (mode 0, MSB first) that receives 16-bit write frames from an external controller and holds the five configuration registers read by the PWM peripheral.
- Sits directly upstream of the PWM block.
- Pads ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS enter this block. Register outputs feed the PWM block's enable and duty inputs one-to-one.

Parameters:
- SYNC_STAGES, 2, number of flops in each pad synchronizer; legal values 2..3.
- MAX_ADDR, 4, highest writable register address; writes above it are dropped.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- sclk  input  1  SPI clock pad, asynchronous to clk
- copi  input  1  SPI data in, asynchronous
- ncs  input  1  SPI chip select, active-low, asynchronous
- cipo  output  1  SPI data out; readback only, else constant 0
- en_reg_out_7_0  output  8  reg 0x00, output enables 7:0
- en_reg_out_15_8  output  8  reg 0x01, output enables 15:8
- en_reg_pwm_7_0  output  8  reg 0x02, PWM enables 7:0
- en_reg_pwm_15_8  output  8  reg 0x03, PWM enables 15:8
- pwm_duty_cycle  output  8  reg 0x04, duty (0x00=0%, 0xFF=100%)

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - All five registers 0x00, cipo 0, state IDLE, shift register 0, bit counter 0.
  - Synchronizer flops reset to idle pad levels: sclk=0, ncs=1, copi=0.
- Synchronization:
  - sclk, copi and ncs each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Edges are single-cycle pulses: sclk_rise, sclk_fall, ncs_fall, ncs_rise.
  - Requirement: f_clk >= 4 * f_sclk.
- Frame format:
  - bit15 = R/W (1 = write, 0 = read).
  - bits14:8 = address.
  - bits7:0 = data.
- States:
  - IDLE: wait for ncs_fall, then clear the counter and go to SHIFT.
  - SHIFT:
    - On sclk_rise, shift synchronized copi into the 16-bit shift register LSB, MSB first.
    - Counter is 5 bits and increments, saturating at 17.
    - On ncs_rise, go to COMMIT.
  - COMMIT (exactly 1 cycle):
    - If counter==16, R/W==1 and addr<=MAX_ADDR, write data to the addressed register.
    - Otherwise no register changes.
    - Always returns to IDLE.
- Latency: register output changes on the clk edge that ends COMMIT, i.e. SYNC_STAGES+2 clk cycles after the ncs pad rises.
- Boundary conditions:
  - Short frame (<16 bits) or long frame (>16 bits): discarded silently.
  - Address 0x05..0x7F: discarded; registers unchanged.
  - Read frame without readback: discarded.
  - sclk edges while ncs is high: ignored; no shift, no count.
  - rst_n asserted mid-frame: immediate abort, all outputs to reset values. A frame in progress when reset is released is ignored until the next ncs_fall.
  - Back-to-back frames with ncs high for >= SYNC_STAGES+2 clk: both commit in order.
- Registers hold their values indefinitely between writes; there are no side effects on write.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - After the 8th sclk_rise of a read frame (R/W=0), latch register[addr] into a TX shift register. Addresses > MAX_ADDR latch 0x00.
  - On each subsequent sclk_fall, drive the next bit on cipo, MSB first, so the controller samples bits 7..0 on sclk rises 9..16.
  - cipo returns to 0 on ncs_rise.
  - Read frames never modify registers.
- Undefined: cipo is tied to 0; read frames are discarded as above.

Decomposition:
- Package spi_reg_pkg:
  - Address constants ADDR_EN_OUT_7_0=7'h00, ADDR_EN_OUT_15_8=7'h01, ADDR_EN_PWM_7_0=7'h02, ADDR_EN_PWM_15_8=7'h03, ADDR_PWM_DUTY=7'h04.
  - FRAME_BITS=16.
  - State enum {IDLE, SHIFT, COMMIT}.
- Sub-module sync_edge_detect: SYNC_STAGES synchronizer plus rise/fall pulse outputs, parameterized reset level. Instantiated once each for sclk, copi and ncs; the copi instance uses only its level output.

Test Plan:
- Reset: assert rst_n=0 with random pad levels -> all five registers 0x00, cipo=0. Release -> unchanged until first valid frame.
- Valid write: frame 0x8055 (write, addr 0x00, data 0x55) at f_sclk = f_clk/8 -> en_reg_out_7_0=0x55 exactly SYNC_STAGES+2 clk after ncs rises; other registers 0x00.
- Duty, then invalid address: write 0x84C0 -> pwm_duty_cycle=0xC0. Then 0x85FF (addr 0x05) -> no register changes.
- Framing errors: 12-bit frame 0x81A, then 20-bit frame 0x82F0F -> both discarded. Following 0x82F0 still commits en_reg_pwm_7_0=0xF0.
- Mid-frame disruption: ncs high after 9 bits, and separately rst_n pulse after 10 bits -> no commit in either case. Reset case also clears all registers. Next full frame 0x83AA -> en_reg_pwm_15_8=0xAA.
- SPI_READBACK_EN: write 0x8133, then read frame 0x0100 -> cipo shifts 0x33 MSB first on sclk rises 9..16. Registers unchanged; cipo=0 after ncs rises.
